pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Control-side counterpart of the ID/EXE pipeline register.
- Examines the ID stage, the ID/EXE register contents and the EXE/MEM access, then drives the PAUSE and FLUSH inputs of PC, IF/ID, ID/EXE and EXE/MEM.
- Resolves three hazards: load-use, taken jump, and the structural conflict where a data access targets shared instruction RAM.
- The structural conflict is handled by a multi-cycle wait FSM. A saturating stall counter is kept for performance debug.

Parameters:
RAM_WAIT_CYCLES, 1, cycles one MEM access to instruction space occupies; legal range 1..15
INST_SPACE_TOP, 16'h8000, data addresses below this value conflict with instruction fetch
PERF_W, 16, stall counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_REG_A_en  in  1  ID instruction reads operand A
id_REG_B_en  in  1  ID instruction reads operand B
id_REG_ADDR_A  in  4  operand A register code (package encoding)
id_REG_ADDR_B  in  4  operand B register code
ie_WB_en  in  1  EXE instruction writes back
ie_WB_ADDR  in  4  EXE destination register code
ie_RAM_EN_op  in  1  EXE instruction accesses RAM
ie_RAM_op  in  1  1 = write, 0 = read
ie_JUMP  in  1  jump/branch taken, resolved in EXE
em_RAM_EN_op  in  1  MEM stage accessing RAM this cycle
em_RAM_ADDR  in  16  MEM access address
perf_clr  in  1  clear stall counter
pc_PAUSE  out  1  hold PC
fi_PAUSE  out  1  hold IF/ID
ie_PAUSE  out  1  hold ID/EXE
em_PAUSE  out  1  hold EXE/MEM
fi_FLUSH  out  1  load bubble into IF/ID
ie_FLUSH  out  1  load bubble into ID/EXE
perf_stall_cnt  out  PERF_W  cycles with pc_PAUSE=1

Behaviour:
- Decided interface rule: one clock, clk; reset rst is synchronous and active-high.
- Clock/reset:
  - While rst=1: all PAUSE/FLUSH outputs are 0, state=RUN, wait_cnt=0, perf_stall_cnt=0.
  - State is updated on the rising clk edge.
- Output timing: all PAUSE/FLUSH outputs are combinational from current state and inputs. They take effect at the next edge (zero-cycle latency).
- Hazard terms:
  - conflict = em_RAM_EN_op & (em_RAM_ADDR < INST_SPACE_TOP).
  - load_use = ie_RAM_EN_op & ~ie_RAM_op & ie_WB_en & ((id_REG_A_en & id_REG_ADDR_A==ie_WB_ADDR) | (id_REG_B_en & id_REG_ADDR_B==ie_WB_ADDR)).
- FSM states: RUN, MEM_WAIT. wait_cnt is 4 bits.
- RUN, conflict, RAM_WAIT_CYCLES>1:
  - FREEZE: pc/fi/ie/em_PAUSE=1, FLUSH=0.
  - Next state MEM_WAIT, wait_cnt=RAM_WAIT_CYCLES-1.
- MEM_WAIT:
  - If wait_cnt>1: FREEZE, then decrement wait_cnt.
  - If wait_cnt==1: FINAL cycle, next state RUN.
  - Inputs are frozen and are not sampled for new hazards.
- RUN with conflict and RAM_WAIT_CYCLES==1 is also a FINAL cycle. RUN without conflict is a NORMAL cycle.
- NORMAL/FINAL cycle priority, highest first:
  1. ie_JUMP: fi_FLUSH=1, ie_FLUSH=1, pc_PAUSE=0 (PC loads target). load_use is ignored because the ID instruction is wrong-path.
  2. load_use: pc_PAUSE=1, fi_PAUSE=1, ie_FLUSH=1. Exactly 1 bubble.
  3. FINAL without 1/2: pc_PAUSE=1, fi_FLUSH=1 (the lost fetch becomes a bubble).
  4. Otherwise all outputs 0.
- Output invariants:
  - em_PAUSE is asserted only in FREEZE.
  - A register never receives PAUSE and FLUSH in the same cycle; PAUSE wins for the same register (case 2 during FINAL).
  - A total access of N=RAM_WAIT_CYCLES cycles gives N-1 FREEZE cycles plus 1 FINAL.
- Counter:
  - perf_stall_cnt increments on each cycle with pc_PAUSE=1 and saturates at all-ones.
  - perf_clr zeroes it, taking priority over increment.
- Reset mid-MEM_WAIT: return to RUN on the next edge; the counter clears.

Decomposition:
- Shared package (define.v): 4-bit register codes R0..R7=0..7, SP=8, IH=9, RA=10, T=11; PAUSE_ENABLE; FLUSH_ENABLE; RAM_OP read/write codes.
- Sub-module hazard_ram_wait holds the FSM plus wait_cnt and exports freeze/final. Hazard priority logic and the counter stay in the top level.

Test Plan:
- load_use: ie lw R3 (RAM_EN=1, RAM_op=0, WB_ADDR=3), id uses A=3 -> exactly 1 cycle of pc_PAUSE=1, fi_PAUSE=1, ie_FLUSH=1; perf_stall_cnt=1.
- Taken jump: ie_JUMP=1 concurrent with a load_use match -> fi_FLUSH=1, ie_FLUSH=1, pc_PAUSE=0; counter unchanged.
- Structural conflict, RAM_WAIT_CYCLES=3, em_RAM_ADDR=16'h4000 -> 2 FREEZE cycles (all four PAUSE=1), then pc_PAUSE=1, fi_FLUSH=1; counter=3. Repeat with address 16'h8000 -> no response.
- FINAL with load_use pending -> fi_PAUSE=1, fi_FLUSH=0, ie_FLUSH=1; FINAL with ie_JUMP -> pc_PAUSE=0.
- rst asserted after the first FREEZE cycle -> next cycle outputs all 0, state RUN, counter 0; a fresh conflict restarts the full 3-cycle sequence.
- PERF_W=4 with 20 load-use stalls -> counter holds 15; perf_clr -> 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller.
// Register codes, enable levels, RAM op codes, FSM states.
package pipe_hazard_ctrl_pkg;

    localparam logic [3:0] REG_R0 = 4'd0;
    localparam logic [3:0] REG_R1 = 4'd1;
    localparam logic [3:0] REG_R2 = 4'd2;
    localparam logic [3:0] REG_R3 = 4'd3;
    localparam logic [3:0] REG_R4 = 4'd4;
    localparam logic [3:0] REG_R5 = 4'd5;
    localparam logic [3:0] REG_R6 = 4'd6;
    localparam logic [3:0] REG_R7 = 4'd7;
    localparam logic [3:0] REG_SP = 4'd8;
    localparam logic [3:0] REG_IH = 4'd9;
    localparam logic [3:0] REG_RA = 4'd10;
    localparam logic [3:0] REG_T  = 4'd11;

    localparam logic PAUSE_ENABLE = 1'b1;
    localparam logic FLUSH_ENABLE = 1'b1;

    localparam logic RAM_READ  = 1'b0;
    localparam logic RAM_WRITE = 1'b1;

    typedef enum logic {
        HZ_RUN      = 1'b0,
        HZ_MEM_WAIT = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic pc_pause;
        logic fi_pause;
        logic ie_pause;
        logic em_pause;
        logic fi_flush;
        logic ie_flush;
    } hz_ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle seen by the hazard controller.
// master = datapath, slave = controller.
interface pipe_hazard_ctrl_if;

    logic        id_REG_A_en;
    logic        id_REG_B_en;
    logic [3:0]  id_REG_ADDR_A;
    logic [3:0]  id_REG_ADDR_B;
    logic        ie_WB_en;
    logic [3:0]  ie_WB_ADDR;
    logic        ie_RAM_EN_op;
    logic        ie_RAM_op;
    logic        ie_JUMP;
    logic        em_RAM_EN_op;
    logic [15:0] em_RAM_ADDR;

    logic        pc_PAUSE;
    logic        fi_PAUSE;
    logic        ie_PAUSE;
    logic        em_PAUSE;
    logic        fi_FLUSH;
    logic        ie_FLUSH;

    modport master (
        output id_REG_A_en, id_REG_B_en,
        output id_REG_ADDR_A, id_REG_ADDR_B,
        output ie_WB_en, ie_WB_ADDR,
        output ie_RAM_EN_op, ie_RAM_op, ie_JUMP,
        output em_RAM_EN_op, em_RAM_ADDR,
        input  pc_PAUSE, fi_PAUSE, ie_PAUSE, em_PAUSE,
        input  fi_FLUSH, ie_FLUSH
    );

    modport slave (
        input  id_REG_A_en, id_REG_B_en,
        input  id_REG_ADDR_A, id_REG_ADDR_B,
        input  ie_WB_en, ie_WB_ADDR,
        input  ie_RAM_EN_op, ie_RAM_op, ie_JUMP,
        input  em_RAM_EN_op, em_RAM_ADDR,
        output pc_PAUSE, fi_PAUSE, ie_PAUSE, em_PAUSE,
        output fi_FLUSH, ie_FLUSH
    );

endinterface

// File: rtl/pipe_hazard_ctrl_ram_wait.sv
// Wait FSM for MEM accesses into instruction RAM.
// Flags FREEZE cycles and the one FINAL cycle of each access.
module hazard_ram_wait
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned RAM_WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic conflict_i,
    output logic freeze_o,
    output logic final_o
);

    localparam logic [3:0] WAIT_INIT = 4'(RAM_WAIT_CYCLES - 1);

    hz_state_e  state_q, state_d;
    logic [3:0] wait_q, wait_d;

    // State and remaining-wait registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HZ_RUN;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next state plus FREEZE / FINAL classification of this cycle.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        freeze_o = 1'b0;
        final_o  = 1'b0;
        unique case (state_q)
            HZ_RUN: begin
                if (conflict_i) begin
                    if (RAM_WAIT_CYCLES > 1) begin
                        freeze_o = 1'b1;
                        state_d  = HZ_MEM_WAIT;
                        wait_d   = WAIT_INIT;
                    end else begin
                        final_o = 1'b1;
                    end
                end
            end
            HZ_MEM_WAIT: begin
                if (wait_q > 4'd1) begin
                    freeze_o = 1'b1;
                    wait_d   = wait_q - 4'd1;
                end else begin
                    final_o = 1'b1;
                    state_d = HZ_RUN;
                    wait_d  = 4'd0;
                end
            end
            default: begin
                state_d = HZ_RUN;
                wait_d  = 4'd0;
            end
        endcase
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use, taken jump, instruction-RAM conflict.
// Drives PAUSE/FLUSH of PC, IF/ID, ID/EXE, EXE/MEM; counts stall cycles.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned RAM_WAIT_CYCLES = 1,
    parameter logic [15:0] INST_SPACE_TOP  = 16'h8000,
    parameter int unsigned PERF_W          = 16
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz,
    input  logic               perf_clr,
    output logic [PERF_W-1:0]  perf_stall_cnt
);

    logic        conflict;
    logic        load_use;
    logic        freeze;
    logic        final_cyc;
    logic        a_hit;
    logic        b_hit;
    hz_ctrl_t    ctrl;
    logic [PERF_W-1:0] perf_q, perf_d;

    assign conflict = hz.em_RAM_EN_op
                    & (hz.em_RAM_ADDR < INST_SPACE_TOP);

    assign a_hit = hz.id_REG_A_en
                 & (hz.id_REG_ADDR_A == hz.ie_WB_ADDR);
    assign b_hit = hz.id_REG_B_en
                 & (hz.id_REG_ADDR_B == hz.ie_WB_ADDR);

    assign load_use = hz.ie_RAM_EN_op
                    & (hz.ie_RAM_op == RAM_READ)
                    & hz.ie_WB_en
                    & (a_hit | b_hit);

    hazard_ram_wait #(
        .RAM_WAIT_CYCLES (RAM_WAIT_CYCLES)
    ) u_ram_wait (
        .clk        (clk),
        .rst        (rst),
        .conflict_i (conflict),
        .freeze_o   (freeze),
        .final_o    (final_cyc)
    );

    // Priority: freeze, jump, load-use, lost fetch on FINAL.
    // Every branch drives each register with PAUSE or FLUSH, never both.
    always_comb begin
        ctrl = '0;
        if (rst) begin
            ctrl = '0;
        end else if (freeze) begin
            ctrl.pc_pause = PAUSE_ENABLE;
            ctrl.fi_pause = PAUSE_ENABLE;
            ctrl.ie_pause = PAUSE_ENABLE;
            ctrl.em_pause = PAUSE_ENABLE;
        end else if (hz.ie_JUMP) begin
            ctrl.fi_flush = FLUSH_ENABLE;
            ctrl.ie_flush = FLUSH_ENABLE;
        end else if (load_use) begin
            ctrl.pc_pause = PAUSE_ENABLE;
            ctrl.fi_pause = PAUSE_ENABLE;
            ctrl.ie_flush = FLUSH_ENABLE;
        end else if (final_cyc) begin
            ctrl.pc_pause = PAUSE_ENABLE;
            ctrl.fi_flush = FLUSH_ENABLE;
        end
    end

    assign hz.pc_PAUSE = ctrl.pc_pause;
    assign hz.fi_PAUSE = ctrl.fi_pause;
    assign hz.ie_PAUSE = ctrl.ie_pause;
    assign hz.em_PAUSE = ctrl.em_pause;
    assign hz.fi_FLUSH = ctrl.fi_flush;
    assign hz.ie_FLUSH = ctrl.ie_flush;

    // Saturating stall counter; clear beats increment.
    always_comb begin
        perf_d = perf_q;
        if (perf_clr) begin
            perf_d = '0;
        end else if (ctrl.pc_pause && (perf_q != '1)) begin
            perf_d = perf_q + 1'b1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_cnt = perf_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl.
// dut_a: 3-cycle RAM wait, 4-bit counter; dut_b: 1-cycle wait.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    logic clk;
    logic rst;
    logic perf_clr;
    logic [3:0]  cnt_a;
    logic [15:0] cnt_b;

    int n_vec;
    int n_err;

    pipe_hazard_ctrl_if hz_a ();
    pipe_hazard_ctrl_if hz_b ();

    assign hz_b.id_REG_A_en   = hz_a.id_REG_A_en;
    assign hz_b.id_REG_B_en   = hz_a.id_REG_B_en;
    assign hz_b.id_REG_ADDR_A = hz_a.id_REG_ADDR_A;
    assign hz_b.id_REG_ADDR_B = hz_a.id_REG_ADDR_B;
    assign hz_b.ie_WB_en      = hz_a.ie_WB_en;
    assign hz_b.ie_WB_ADDR    = hz_a.ie_WB_ADDR;
    assign hz_b.ie_RAM_EN_op  = hz_a.ie_RAM_EN_op;
    assign hz_b.ie_RAM_op     = hz_a.ie_RAM_op;
    assign hz_b.ie_JUMP       = hz_a.ie_JUMP;
    assign hz_b.em_RAM_EN_op  = hz_a.em_RAM_EN_op;
    assign hz_b.em_RAM_ADDR   = hz_a.em_RAM_ADDR;

    pipe_hazard_ctrl #(
        .RAM_WAIT_CYCLES (3),
        .INST_SPACE_TOP  (16'h8000),
        .PERF_W          (4)
    ) dut_a (
        .clk            (clk),
        .rst            (rst),
        .hz             (hz_a),
        .perf_clr       (perf_clr),
        .perf_stall_cnt (cnt_a)
    );

    pipe_hazard_ctrl #(
        .RAM_WAIT_CYCLES (1),
        .INST_SPACE_TOP  (16'h8000),
        .PERF_W          (16)
    ) dut_b (
        .clk            (clk),
        .rst            (rst),
        .hz             (hz_b),
        .perf_clr       (perf_clr),
        .perf_stall_cnt (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_P, fi_P, ie_P, em_P, fi_F, ie_F}
    localparam logic [5:0] O_NONE   = 6'b000000;
    localparam logic [5:0] O_LU     = 6'b110001;
    localparam logic [5:0] O_JMP    = 6'b000011;
    localparam logic [5:0] O_FRZ    = 6'b111100;
    localparam logic [5:0] O_FINAL  = 6'b100010;

    function automatic logic [5:0] outs_a();
        return {hz_a.pc_PAUSE, hz_a.fi_PAUSE, hz_a.ie_PAUSE,
                hz_a.em_PAUSE, hz_a.fi_FLUSH, hz_a.ie_FLUSH};
    endfunction

    function automatic logic [5:0] outs_b();
        return {hz_b.pc_PAUSE, hz_b.fi_PAUSE, hz_b.ie_PAUSE,
                hz_b.em_PAUSE, hz_b.fi_FLUSH, hz_b.ie_FLUSH};
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz_a.id_REG_A_en   = 1'b0;
        hz_a.id_REG_B_en   = 1'b0;
        hz_a.id_REG_ADDR_A = REG_R0;
        hz_a.id_REG_ADDR_B = REG_R0;
        hz_a.ie_WB_en      = 1'b0;
        hz_a.ie_WB_ADDR    = REG_R0;
        hz_a.ie_RAM_EN_op  = 1'b0;
        hz_a.ie_RAM_op     = RAM_READ;
        hz_a.ie_JUMP       = 1'b0;
        hz_a.em_RAM_EN_op  = 1'b0;
        hz_a.em_RAM_ADDR   = 16'h0000;
    endtask

    // lw R3 in EXE; ID reads R3 on port A
    task automatic set_load_use();
        hz_a.ie_RAM_EN_op  = 1'b1;
        hz_a.ie_RAM_op     = RAM_READ;
        hz_a.ie_WB_en      = 1'b1;
        hz_a.ie_WB_ADDR    = REG_R3;
        hz_a.id_REG_A_en   = 1'b1;
        hz_a.id_REG_ADDR_A = REG_R3;
    endtask

    task automatic set_conflict(input logic [15:0] addr);
        hz_a.em_RAM_EN_op = 1'b1;
        hz_a.em_RAM_ADDR  = addr;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        perf_clr = 1'b0;
        idle();
        set_conflict(16'h4000);
        set_load_use();
        tick();
        tick();
        chk("rst_outs_a", 32'(outs_a()), 32'(O_NONE));
        chk("rst_outs_b", 32'(outs_b()), 32'(O_NONE));
        chk("rst_cnt_a", 32'(cnt_a), 32'd0);
        rst = 1'b0;
        idle();
        #1;
        chk("idle_outs", 32'(outs_a()), 32'(O_NONE));

        // load-use on port A: one bubble
        set_load_use();
        #1;
        chk("lu_outs", 32'(outs_a()), 32'(O_LU));
        tick();
        idle();
        #1;
        chk("lu_after", 32'(outs_a()), 32'(O_NONE));
        chk("lu_cnt", 32'(cnt_a), 32'd1);

        // port B match, and non-hazard variants
        set_load_use();
        hz_a.id_REG_A_en   = 1'b0;
        hz_a.id_REG_B_en   = 1'b1;
        hz_a.id_REG_ADDR_B = REG_R3;
        #1;
        chk("lu_b_outs", 32'(outs_a()), 32'(O_LU));
        hz_a.id_REG_B_en = 1'b0;
        #1;
        chk("lu_no_en", 32'(outs_a()), 32'(O_NONE));
        hz_a.id_REG_A_en = 1'b1;
        hz_a.ie_RAM_op   = RAM_WRITE;
        #1;
        chk("store_no_lu", 32'(outs_a()), 32'(O_NONE));
        hz_a.ie_RAM_op     = RAM_READ;
        hz_a.id_REG_ADDR_A = REG_SP;
        #1;
        chk("lu_diff_reg", 32'(outs_a()), 32'(O_NONE));

        // jump beats load-use; counter holds
        set_load_use();
        hz_a.ie_JUMP = 1'b1;
        #1;
        chk("jmp_outs", 32'(outs_a()), 32'(O_JMP));
        tick();
        idle();
        #1;
        chk("jmp_cnt", 32'(cnt_a), 32'd1);

        // conflict: 2 FREEZE + FINAL on dut_a; FINAL on dut_b
        set_conflict(16'h4000);
        #1;
        chk("cf_frz0", 32'(outs_a()), 32'(O_FRZ));
        chk("cf_b_final", 32'(outs_b()), 32'(O_FINAL));
        tick();
        hz_a.ie_JUMP = 1'b1;
        #1;
        chk("cf_frz1_jmp", 32'(outs_a()), 32'(O_FRZ));
        hz_a.ie_JUMP = 1'b0;
        tick();
        #1;
        chk("cf_final", 32'(outs_a()), 32'(O_FINAL));
        tick();
        idle();
        #1;
        chk("cf_cnt", 32'(cnt_a), 32'd4);
        chk("cf_done", 32'(outs_a()), 32'(O_NONE));

        // boundary address: no conflict
        set_conflict(16'h8000);
        #1;
        chk("cf_8000", 32'(outs_a()), 32'(O_NONE));
        chk("cf_8000_b", 32'(outs_b()), 32'(O_NONE));
        tick();
        #1;
        chk("cf_8000_cnt", 32'(cnt_a), 32'd4);
        set_conflict(16'h7FFF);
        #1;
        chk("cf_7fff", 32'(outs_a()), 32'(O_FRZ));
        tick();
        tick();
        #1;
        chk("cf_7fff_fin", 32'(outs_a()), 32'(O_FINAL));
        tick();
        idle();
        #1;
        chk("cf_7fff_cnt", 32'(cnt_a), 32'd7);

        // FINAL with load-use pending: PAUSE wins on IF/ID
        set_conflict(16'h1000);
        tick();
        tick();
        set_load_use();
        #1;
        chk("fin_lu", 32'(outs_a()), 32'(O_LU));
        tick();
        idle();
        #1;
        chk("fin_lu_cnt", 32'(cnt_a), 32'd10);

        // FINAL with jump: PC loads target
        set_conflict(16'h1000);
        tick();
        tick();
        hz_a.ie_JUMP = 1'b1;
        #1;
        chk("fin_jmp", 32'(outs_a()), 32'(O_JMP));
        tick();
        idle();
        #1;
        chk("fin_jmp_cnt", 32'(cnt_a), 32'd12);

        // reset after first FREEZE cycle
        set_conflict(16'h4000);
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mid", 32'(outs_a()), 32'(O_NONE));
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_cnt", 32'(cnt_a), 32'd0);
        chk("rst_restart", 32'(outs_a()), 32'(O_FRZ));
        tick();
        #1;
        chk("rst_frz1", 32'(outs_a()), 32'(O_FRZ));
        tick();
        #1;
        chk("rst_final", 32'(outs_a()), 32'(O_FINAL));
        tick();
        idle();
        #1;
        chk("rst_seq_cnt", 32'(cnt_a), 32'd3);
        chk("rst_seq_cnt_b", 32'(cnt_b), 32'd3);

        // 20 load-use stalls: 4-bit counter saturates
        set_load_use();
        for (int i = 0; i < 20; i++) tick();
        idle();
        #1;
        chk("sat_cnt_a", 32'(cnt_a), 32'd15);
        chk("sat_cnt_b", 32'(cnt_b), 32'd23);

        // clear beats increment
        set_load_use();
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        idle();
        #1;
        chk("clr_cnt_a", 32'(cnt_a), 32'd0);
        chk("clr_cnt_b", 32'(cnt_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
